// File: rtl/mem_arbiter.sv
// Two-client line-memory arbiter (I-cache fill, D-cache fill/writeback) with watchdog abort.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise D wins every tie.
module mem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic              i_err,
    output logic [DATA_W-1:0] i_rd_data,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wr_data,
    output logic              d_done,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rd_data,
    output logic              busy,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_re,
    output logic              m_we,
    output logic [DATA_W-1:0] m_wr_data,
    input  logic [DATA_W-1:0] m_rd_data,
    input  logic              m_rdy
);

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t              r_state;
    state_t              w_nextState;
    logic                r_owner;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_we;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [7:0]          r_waitCnt;
    logic                w_grant;
    logic                w_grantD;
`ifdef MEM_ARB_RR_EN
    logic                r_lastGnt;
`endif

    // Owner encoding: 1 = D side, 0 = I side.
    always_comb begin
        w_grant = i_req | d_req;
`ifdef MEM_ARB_RR_EN
        w_grantD = d_req & (~i_req | ~r_lastGnt);
`else
        w_grantD = d_req;
`endif
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_nextState = XFER;
            XFER:    if (m_rdy || (r_waitCnt == WAIT_LAST)) w_nextState = RESP;
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Request latching on grant, watchdog count and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_we      <= 1'b0;
            r_rdata   <= '0;
            r_err     <= 1'b0;
            r_waitCnt <= '0;
`ifdef MEM_ARB_RR_EN
            r_lastGnt <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_owner   <= w_grantD;
                        r_addr    <= w_grantD ? d_addr : i_addr;
                        r_wdata   <= w_grantD ? d_wr_data : '0;
                        r_we      <= w_grantD & d_we;
                        r_waitCnt <= '0;
`ifdef MEM_ARB_RR_EN
                        r_lastGnt <= w_grantD;
`endif
                    end
                end
                XFER: begin
                    r_waitCnt <= r_waitCnt + 8'd1;
                    if (m_rdy) begin
                        r_rdata <= m_rd_data;
                        r_err   <= 1'b0;
                    end else if (r_waitCnt == WAIT_LAST) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state != IDLE);
    assign m_re      = (r_state == XFER) & ~r_we;
    assign m_we      = (r_state == XFER) & r_we;
    assign m_addr    = (r_state == XFER) ? r_addr : '0;
    assign m_wr_data = (r_state == XFER) ? r_wdata : '0;

    assign i_done    = (r_state == RESP) & ~r_owner;
    assign d_done    = (r_state == RESP) & r_owner;
    assign i_err     = i_done & r_err;
    assign d_err     = d_done & r_err;
    assign i_rd_data = r_rdata;
    assign d_rd_data = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
// Build with MEM_ARB_RR_EN defined to check the round-robin variant.
module tb_mem_arbiter;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 64;
    localparam int MAX_WAIT = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic              i_err;
    logic [DATA_W-1:0] i_rd_data;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wr_data;
    logic              d_done;
    logic              d_err;
    logic [DATA_W-1:0] d_rd_data;
    logic              busy;
    logic [ADDR_W-1:0] m_addr;
    logic              m_re;
    logic              m_we;
    logic [DATA_W-1:0] m_wr_data;
    logic [DATA_W-1:0] m_rd_data;
    logic              m_rdy;

    int testCount = 0;
    int failCount = 0;

    // Model: outstanding requests per side plus who won the last grant.
    logic              pendI, pendD, pendDWe;
    logic [ADDR_W-1:0] pendIAddr, pendDAddr;
    logic [DATA_W-1:0] pendDData;
    logic              modelLastD;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_err(i_err), .i_rd_data(i_rd_data),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wr_data(d_wr_data),
        .d_done(d_done), .d_err(d_err), .d_rd_data(d_rd_data),
        .busy(busy), .m_addr(m_addr), .m_re(m_re), .m_we(m_we), .m_wr_data(m_wr_data),
        .m_rd_data(m_rd_data), .m_rdy(m_rdy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Tie resolution straight from the arbitration rules.
    function automatic logic pickD();
`ifdef MEM_ARB_RR_EN
        return ~modelLastD;
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // Entered and left at the falling edge of an IDLE cycle.
    // k = XFER cycle in which m_rdy is raised; k > MAX_WAIT means never.
    task automatic applyStimulus(input logic newI, input logic newD, input logic [ADDR_W-1:0] iAddr,
                                 input logic dWe, input logic [ADDR_W-1:0] dAddr,
                                 input logic [DATA_W-1:0] dData, input int k,
                                 input logic [DATA_W-1:0] rdVal);
        logic              winD;
        logic              expErr;
        logic              expWe;
        logic [ADDR_W-1:0] expAddr;
        logic [DATA_W-1:0] expWData;
        int                n;
        checkOutput("idle_busy", busy, 0);
        if (newI && !pendI) begin
            pendI = 1'b1; pendIAddr = iAddr;
            i_req = 1'b1; i_addr = iAddr;
        end
        if (newD && !pendD) begin
            pendD = 1'b1; pendDAddr = dAddr; pendDWe = dWe; pendDData = dData;
            d_req = 1'b1; d_addr = dAddr; d_we = dWe; d_wr_data = dData;
        end
        winD       = (pendI && pendD) ? pickD() : pendD;
        modelLastD = winD;
        expAddr    = winD ? pendDAddr : pendIAddr;
        expWe      = winD & pendDWe;
        expWData   = pendDData;
        n          = (k <= MAX_WAIT) ? k : MAX_WAIT;
        expErr     = (k > MAX_WAIT);
        m_rdy      = 1'($urandom_range(0, 1));
        m_rd_data  = rand64();
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (j == 1) begin
                if (winD) d_addr = ~pendDAddr;
                else      i_addr = ~pendIAddr;
                d_wr_data = ~d_wr_data;
            end
            checkOutput("xfer_m_re", m_re, !expWe);
            checkOutput("xfer_m_we", m_we, expWe);
            checkOutput("xfer_m_addr", m_addr, expAddr);
            checkOutput("xfer_busy", busy, 1);
            checkOutput("xfer_no_done", {i_done, d_done}, 0);
            if (expWe) checkOutput("xfer_m_wr_data", m_wr_data, expWData);
            m_rdy     = (j == k);
            m_rd_data = (j == k) ? rdVal : rand64();
        end
        @(negedge clk);
        checkOutput("resp_i_done", i_done, !winD);
        checkOutput("resp_d_done", d_done, winD);
        checkOutput("resp_i_err", i_err, !winD && expErr);
        checkOutput("resp_d_err", d_err, winD && expErr);
        checkOutput("resp_strobes", {m_re, m_we}, 0);
        if (expErr) begin
            checkOutput("resp_rd_zero_i", i_rd_data, 0);
            checkOutput("resp_rd_zero_d", d_rd_data, 0);
        end else if (!expWe) begin
            checkOutput("resp_i_rd_data", i_rd_data, rdVal);
            checkOutput("resp_d_rd_data", d_rd_data, rdVal);
        end
        if (winD) begin
            d_req = 1'b0; pendD = 1'b0;
        end else begin
            i_req = 1'b0; pendI = 1'b0;
        end
        m_rdy = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [ADDR_W-1:0] ra, rb;
        logic              ni, nd;
        rst = 1'b1;
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wr_data = '0;
        m_rd_data = '0; m_rdy = 0;
        pendI = 0; pendD = 0; pendDWe = 0; pendIAddr = '0; pendDAddr = '0; pendDData = '0;
        modelLastD = 0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_strobes", {m_re, m_we}, 0);
        checkOutput("reset_m_addr", m_addr, 0);
        checkOutput("reset_dones", {i_done, d_done, i_err, d_err}, 0);
        checkOutput("reset_rd_data", i_rd_data, 0);
        rst = 1'b0;
        @(negedge clk);

        // Three tie rounds straight out of reset.
        for (int r = 0; r < 3; r++)
            applyStimulus(1, 1, 14'($urandom), 0, 14'($urandom), rand64(), 2, rand64());
        // Clear any leftover pending request.
        while (pendI || pendD)
            applyStimulus(0, 0, '0, 0, '0, '0, 1, rand64());

        applyStimulus(1, 0, 14'h0123, 0, '0, '0, 4, 64'hDEADBEEF_CAFEF00D);
        applyStimulus(0, 1, '0, 1, 14'h3FFF, 64'h1111_2222_3333_4444, 1, rand64());
        applyStimulus(0, 1, '0, 0, 14'h0040, '0, MAX_WAIT + 5, rand64());
        applyStimulus(0, 1, '0, 0, 14'h0041, '0, MAX_WAIT, 64'h0123_4567_89AB_CDEF);

        // Asynchronous reset in the middle of a transfer.
        i_req = 1'b1; i_addr = 14'h0AAA;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("async_rst_strobes", {m_re, m_we}, 0);
        checkOutput("async_rst_busy", busy, 0);
        checkOutput("async_rst_done", {i_done, d_done}, 0);
        i_req = 1'b0;
        @(negedge clk);
        checkOutput("rst_hold_done", {i_done, d_done}, 0);
        rst = 1'b0;
        pendI = 0; pendD = 0; modelLastD = 0;
        @(negedge clk);
        applyStimulus(1, 0, 14'h0155, 0, '0, '0, 3, 64'hA5A5_5A5A_0F0F_F0F0);

        for (int t = 0; t < 60; t++) begin
            ni = 1'($urandom_range(0, 1));
            nd = 1'($urandom_range(0, 1));
            if (!ni && !nd && !pendI && !pendD) ni = 1'b1;
            ra = 14'($urandom);
            rb = 14'($urandom);
            applyStimulus(ni, nd, ra, 1'($urandom_range(0, 1)), rb, rand64(),
                          $urandom_range(1, MAX_WAIT + 3), rand64());
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
